// File: rtl/round_seq_xn.sv
// Control sequencer for an unrolled SKINNY datapath: LOAD beats, RUN rounds, OUT beats,
// optional counter update, then a one-cycle DONE pulse.
module round_seq_xn #(
  parameter int unsigned UNROLL = 4,
  parameter int unsigned ROUNDS = 56,
  parameter int unsigned BUSW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dec,
  input  logic              inc,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              sse,
  output logic              xse,
  output logic              yse,
  output logic              senc,
  output logic              xenc,
  output logic              yenc,
  output logic              zenc,
  output logic              zse,
  output logic              erst,
  output logic [BUSW/8-1:0] dec_mask,
  output logic [7:0]        round_cnt,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NW      = 128 / BUSW;
  localparam int unsigned RUN_CYC = ROUNDS / UNROLL;
  localparam int unsigned BW      = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned RW      = 8;

  // Reject illegal parameterisations at elaboration time.
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("round_seq_xn: UNROLL must be 1, 2, 4 or 8");
  end
  if (ROUNDS % UNROLL != 0) begin : g_bad_rounds
    $error("round_seq_xn: ROUNDS must be a multiple of UNROLL");
  end
  if (BUSW != 32 && BUSW != 64 && BUSW != 128) begin : g_bad_busw
    $error("round_seq_xn: BUSW must be 32, 64 or 128");
  end
  if (RUN_CYC > 256 || RUN_CYC == 0) begin : g_bad_runcyc
    $error("round_seq_xn: ROUNDS/UNROLL must be 1..256");
  end

  typedef enum logic [2:0] {IDLE, LOAD, RUN, OUT, CNT, DONE} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] beat_cnt;
  logic [RW-1:0] rnd_cnt;
  logic          dec_q, inc_q;
  logic          beat_last, rnd_last;

  assign beat_last = (beat_cnt == BW'(NW - 1));
  assign rnd_last  = (rnd_cnt == RW'(RUN_CYC - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Beat/round counters and mode latches; counters wrap to 0 so each phase enters at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      rnd_cnt  <= '0;
      dec_q    <= 1'b0;
      inc_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          beat_cnt <= '0;
          rnd_cnt  <= '0;
          if (start) begin
            dec_q <= dec;
            inc_q <= inc;
          end
        end
        LOAD: if (din_valid)  beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
        RUN:                  rnd_cnt  <= rnd_last ? '0 : rnd_cnt + RW'(1);
        OUT:  if (dout_ready) beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (din_valid && beat_last) state_nxt = RUN;
      RUN:     if (rnd_last) state_nxt = OUT;
      OUT:     if (dout_ready && beat_last) state_nxt = inc_q ? CNT : DONE;
      CNT:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; everything is forced low while rst is asserted.
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    sse        = 1'b0;
    xse        = 1'b0;
    yse        = 1'b0;
    senc       = 1'b0;
    xenc       = 1'b0;
    yenc       = 1'b0;
    zenc       = 1'b0;
    zse        = 1'b0;
    erst       = 1'b0;
    dec_mask   = '0;
    round_cnt  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        LOAD: begin
          din_ready = 1'b1;
          sse       = din_valid;
          xse       = din_valid;
          yse       = din_valid;
        end
        RUN: begin
          senc      = 1'b1;
          xenc      = 1'b1;
          yenc      = 1'b1;
          zenc      = 1'b1;
          erst      = (rnd_cnt == '0);
          round_cnt = rnd_cnt;
        end
        OUT: begin
          dout_valid = 1'b1;
          sse        = dout_ready;
          dec_mask   = dec_q ? '1 : '0;
        end
        CNT:     zse  = 1'b1;
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_round_seq_xn.sv
// Directed bench for round_seq_xn: default instance plus an UNROLL=8/BUSW=128 instance.
module tb_round_seq_xn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, dec, inc, din_valid, dout_ready;
  logic din_ready, dout_valid, sse, xse, yse, senc, xenc, yenc, zenc, zse, erst, busy, done;
  logic [3:0] dec_mask;
  logic [7:0] round_cnt;

  logic start2, dec2, inc2, din_valid2, dout_ready2;
  logic din_ready2, dout_valid2, sse2, xse2, yse2, senc2, xenc2, yenc2, zenc2, zse2, erst2;
  logic busy2, done2;
  logic [15:0] dec_mask2;
  logic [7:0]  round_cnt2;

  int checks = 0;
  int passed = 0;

  round_seq_xn dut (
    .clk(clk), .rst(rst), .start(start), .dec(dec), .inc(inc),
    .din_valid(din_valid), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sse(sse), .xse(xse), .yse(yse),
    .senc(senc), .xenc(xenc), .yenc(yenc), .zenc(zenc),
    .zse(zse), .erst(erst), .dec_mask(dec_mask), .round_cnt(round_cnt),
    .busy(busy), .done(done)
  );

  round_seq_xn #(.UNROLL(8), .ROUNDS(56), .BUSW(128)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dec(dec2), .inc(inc2),
    .din_valid(din_valid2), .din_ready(din_ready2),
    .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .sse(sse2), .xse(xse2), .yse(yse2),
    .senc(senc2), .xenc(xenc2), .yenc(yenc2), .zenc(zenc2),
    .zse(zse2), .erst(erst2), .dec_mask(dec_mask2), .round_cnt(round_cnt2),
    .busy(busy2), .done(done2)
  );

  function automatic logic [12:0] obs1();
    return {din_ready, sse, xse, yse, senc, xenc, yenc, zenc, zse, erst, dout_valid, busy, done};
  endfunction

  function automatic logic [12:0] obs2();
    return {din_ready2, sse2, xse2, yse2, senc2, xenc2, yenc2, zenc2, zse2, erst2, dout_valid2,
            busy2, done2};
  endfunction

  // Expected control vector, same bit order as obs1/obs2.
  function automatic logic [12:0] mk(input logic dr, input logic ss, input logic xs,
                                     input logic rn, input logic zs, input logic er,
                                     input logic dv, input logic bz, input logic dn);
    return {dr, ss, xs, xs, rn, rn, rn, rn, zs, er, dv, bz, dn};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dec = 1'b1; inc = 1'b1; din_valid = 1'b1; dout_ready = 1'b1;
    start2 = 1'b1; dec2 = 1'b1; inc2 = 1'b1; din_valid2 = 1'b1; dout_ready2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (obs1() !== 13'h0 || dec_mask !== 4'h0 || round_cnt !== 8'h0)
        $display("FAIL reset_outs c=%0d got ctl=%h dm=%h rc=%0d want 0", c, obs1(), dec_mask, round_cnt);
      else passed++;
      checks++;
      if (obs2() !== 13'h0 || dec_mask2 !== 16'h0 || round_cnt2 !== 8'h0)
        $display("FAIL reset_outs2 c=%0d got ctl=%h dm=%h rc=%0d want 0", c, obs2(), dec_mask2, round_cnt2);
      else passed++;
      next_cyc();
    end
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (obs1() !== 13'h0 || obs2() !== 13'h0)
        $display("FAIL reset_idle c=%0d got ctl=%h ctl2=%h want 0", c, obs1(), obs2());
      else passed++;
      next_cyc();
    end
  endtask

  // REQ-036 timeline; dec/inc flip after start to prove they are latched.
  task automatic test_nominal(input string tag);
    logic [12:0] e;
    logic ld, rn, ot;
    for (int c = 0; c <= 25; c++) begin
      start = (c == 0); dec = (c != 0); inc = (c == 0); din_valid = 1'b1; dout_ready = 1'b1;
      #1;
      ld = (c >= 1 && c <= 4); rn = (c >= 5 && c <= 18); ot = (c >= 19 && c <= 22);
      e = mk(ld, ld || ot, ld, rn, c == 23, c == 5, ot, c >= 1 && c <= 24, c == 24);
      checks++;
      if (obs1() !== e) $display("FAIL %s_ctl c=%0d got %b want %b", tag, c, obs1(), e);
      else passed++;
      checks++;
      if (round_cnt !== (rn ? 8'(c - 5) : 8'd0) || dec_mask !== 4'h0)
        $display("FAIL %s_rc_dm c=%0d got rc=%0d dm=%h want rc=%0d dm=0", tag, c, round_cnt,
                 dec_mask, rn ? c - 5 : 0);
      else passed++;
      next_cyc();
    end
  endtask

  // REQ-037: din_valid low in cycles 2-3, inc=0.
  task automatic test_load_stall();
    logic [12:0] e;
    logic ld, acc, rn, ot;
    for (int c = 0; c <= 26; c++) begin
      start = (c == 0); dec = 1'b0; inc = 1'b0; dout_ready = 1'b1;
      din_valid = !(c == 2 || c == 3);
      #1;
      ld = (c >= 1 && c <= 6); acc = ld && din_valid;
      rn = (c >= 7 && c <= 20); ot = (c >= 21 && c <= 24);
      e = mk(ld, acc || ot, acc, rn, 1'b0, c == 7, ot, c >= 1 && c <= 25, c == 25);
      checks++;
      if (obs1() !== e) $display("FAIL stall_ctl c=%0d got %b want %b", c, obs1(), e);
      else passed++;
      checks++;
      if (round_cnt !== (rn ? 8'(c - 7) : 8'd0))
        $display("FAIL stall_rc c=%0d got %0d want %0d", c, round_cnt, rn ? c - 7 : 0);
      else passed++;
      next_cyc();
    end
  endtask

  // REQ-038: dec=1, dout_ready toggles (high on odd cycles).
  task automatic test_dec_toggle();
    logic [12:0] e;
    logic ld, rn, ot;
    int n_sse = 0;
    for (int c = 0; c <= 27; c++) begin
      start = (c == 0); dec = (c == 0); inc = 1'b0; din_valid = 1'b1;
      dout_ready = (c % 2 == 1);
      #1;
      ld = (c >= 1 && c <= 4); rn = (c >= 5 && c <= 18); ot = (c >= 19 && c <= 25);
      e = mk(ld, ld || (ot && dout_ready), ld, rn, 1'b0, c == 5, ot, c >= 1 && c <= 26, c == 26);
      if (ot && sse === 1'b1) n_sse++;
      checks++;
      if (obs1() !== e) $display("FAIL dec_ctl c=%0d got %b want %b", c, obs1(), e);
      else passed++;
      checks++;
      if (dec_mask !== (ot ? 4'hF : 4'h0))
        $display("FAIL dec_mask c=%0d got %h want %h", c, dec_mask, ot ? 4'hF : 4'h0);
      else passed++;
      next_cyc();
    end
    checks++;
    if (n_sse !== 4) $display("FAIL dec_sse_pulses got %0d want 4", n_sse);
    else passed++;
  endtask

  // REQ-039: rst in RUN cycle 10, then a fresh full sequence.
  task automatic test_reset_run();
    logic [12:0] e;
    logic ld, rn;
    for (int c = 0; c <= 11; c++) begin
      start = (c == 0); dec = 1'b0; inc = 1'b1; din_valid = 1'b1; dout_ready = 1'b1;
      rst = (c == 10);
      #1;
      ld = (c >= 1 && c <= 4); rn = (c >= 5 && c <= 9);
      e = mk(ld, ld, ld, rn, 1'b0, c == 5, 1'b0, c >= 1 && c <= 9, 1'b0);
      checks++;
      if (obs1() !== e || round_cnt !== (rn ? 8'(c - 5) : 8'd0))
        $display("FAIL rstrun_ctl c=%0d got %b rc=%0d want %b rc=%0d", c, obs1(), round_cnt, e,
                 rn ? c - 5 : 0);
      else passed++;
      next_cyc();
    end
    rst = 1'b0;
    test_nominal("rerun");
  endtask

  // REQ-040: wide instance; start pulses while busy must be ignored.
  task automatic test_wide();
    logic [12:0] e;
    logic rn, ot;
    for (int c = 0; c <= 12; c++) begin
      start2 = (c == 0 || c == 3 || c == 9 || c == 10);
      dec2 = (c == 0); inc2 = 1'b0; din_valid2 = 1'b1; dout_ready2 = 1'b1;
      #1;
      rn = (c >= 2 && c <= 8); ot = (c == 9);
      e = mk(c == 1, c == 1 || ot, c == 1, rn, 1'b0, c == 2, ot, c >= 1 && c <= 10, c == 10);
      checks++;
      if (obs2() !== e) $display("FAIL wide_ctl c=%0d got %b want %b", c, obs2(), e);
      else passed++;
      checks++;
      if (round_cnt2 !== (rn ? 8'(c - 2) : 8'd0) || dec_mask2 !== (ot ? 16'hFFFF : 16'h0))
        $display("FAIL wide_rc_dm c=%0d got rc=%0d dm=%h want rc=%0d dm=%h", c, round_cnt2,
                 dec_mask2, rn ? c - 2 : 0, ot ? 16'hFFFF : 16'h0);
      else passed++;
      next_cyc();
    end
    start2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dec = 1'b0; inc = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    start2 = 1'b0; dec2 = 1'b0; inc2 = 1'b0; din_valid2 = 1'b0; dout_ready2 = 1'b0;
    next_cyc();
    test_reset();
    test_nominal("nominal");
    test_load_stall();
    test_dec_toggle();
    test_reset_run();
    test_wide();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/round_seq_xn.md
ROUND_SEQ_XN -- requirements
Module: round_seq_xn

Interface
REQ-001 SHALL have parameter UNROLL, default 4: SKINNY rounds per clock of the unrolled datapath; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter ROUNDS, default 56: total rounds per block; elaboration SHALL fail unless ROUNDS % UNROLL == 0.
REQ-003 SHALL have parameter BUSW, default 32: data bus width; legal values 32, 64, 128; NW = 128/BUSW beats per block.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request one block operation; sampled only in IDLE.
REQ-007 dec  in  1  decrypt mode; latched with start.
REQ-008 inc  in  1  counter-update request; latched with start.
REQ-009 din_valid / din_ready  in / out  1 / 1  input beat handshake (pdi and sdi beats together).
REQ-010 dout_valid / dout_ready  out / in  1 / 1  output beat handshake.
REQ-011 sse, xse, yse  out  1 each  shift enables for state, TKX and TKY registers.
REQ-012 senc, xenc, yenc, zenc  out  1 each  round-update enables for state, TKX, TKY and TKZ.
REQ-013 zse  out  1  counter (TKZ) LFSR update enable.
REQ-014 erst  out  1  round-constant init to the unrolled round function.
REQ-015 dec_mask  out  BUSW/8  per-byte decrypt select for the output beat.
REQ-016 round_cnt  out  8  current RUN-cycle index.
REQ-017 busy, done  out  1 / 1  operation in progress / one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, OUT, CNT, DONE.
REQ-019 IDLE: start=1 latches dec and inc and moves to LOAD next cycle; start=0 stays in IDLE.
REQ-020 LOAD: din_ready=1; each cycle with din_valid=1 asserts sse, xse and yse in that same cycle and increments the beat counter; after the NW-th accepted beat the FSM moves to RUN; din_valid=0 stalls with all shift enables low.
REQ-021 RUN: SHALL last exactly ROUNDS/UNROLL cycles with senc, xenc, yenc and zenc high every cycle.
REQ-022 RUN: erst SHALL be high only in the first RUN cycle.
REQ-023 RUN: round_cnt SHALL count 0 .. ROUNDS/UNROLL-1; round_cnt SHALL be 0 in every other state.
REQ-024 OUT: dout_valid=1; each cycle with dout_ready=1 asserts sse and counts one beat; after NW beats the FSM moves to CNT if inc was latched, else to DONE; dout_ready=0 holds dout_valid=1 with sse low.
REQ-025 dec_mask SHALL be all-ones in OUT when latched dec=1, else all-zeros.
REQ-026 CNT: one cycle with zse=1, then DONE.
REQ-027 DONE: one cycle with done=1, then IDLE.
REQ-028 busy SHALL be high in every state except IDLE.
REQ-029 start outside IDLE SHALL be ignored; dec and inc SHALL NOT change mid-operation.
REQ-030 din_valid outside LOAD and dout_ready outside OUT SHALL have no effect.
REQ-031 Shift enables and round enables SHALL never be high in the same cycle.
REQ-032 Beat counter SHALL be 0 on entry to LOAD and to OUT.

Reset
REQ-033 rst=1 SHALL force IDLE on the next edge from any state, including mid-LOAD/RUN/OUT, and clear the beat counter, round counter and latched dec/inc.
REQ-034 During rst and in IDLE, all outputs SHALL be 0; dec_mask=0 and round_cnt=0.
REQ-035 start asserted together with rst SHALL be ignored.

Verification (UNROLL=4, ROUNDS=56, BUSW=32 unless stated)
REQ-036 No stalls, inc=1, start at cycle 0 -> LOAD cycles 1-4 (sse/xse/yse high); RUN cycles 5-18 (erst only at 5); OUT 19-22; zse at 23; done at 24; IDLE at 25.
REQ-037 inc=0, din_valid low in cycles 2-3 -> LOAD spans cycles 1-6 with 4 shift pulses; RUN still 14 cycles; no zse; done one cycle after the last OUT beat.
REQ-038 dec=1, dout_ready toggling 1,0,1,0,... -> dout_valid held high, exactly 4 sse pulses, dec_mask=4'hF throughout OUT.
REQ-039 rst in RUN cycle 10 -> IDLE next cycle, all outputs 0; a fresh start then runs a full 4/14/4 sequence.
REQ-040 UNROLL=8, BUSW=128 -> 1 load beat, 7 RUN cycles, round_cnt 0..6, 1 output beat; start pulses while busy have no effect.
